// File: rtl/fpu_mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one fpu_multiplier among N_REQ requesters,
// with a watchdog that aborts and resets a multiplier that never completes.
module fpu_mul_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [32*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    resp_valid,
    output logic [31:0]         resp_z,
    output logic                resp_err,
    output logic                busy,
    output logic                mul_rst,
    output logic                mul_start,
    output logic [31:0]         mul_a,
    output logic [31:0]         mul_b,
    output logic                mul_a_stb,
    output logic                mul_b_stb,
    input  logic [31:0]         mul_z,
    input  logic                mul_z_stb
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [31:0] ABORT_Z = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CLR, WAIT_DONE, RESPOND, ABORT} state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [WW-1:0]  wd_q, wd_d;
    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [31:0]    resp_z_q, resp_z_d;
    logic           resp_err_q, resp_err_d;
    logic           busy_q, busy_d;
    logic           mul_start_q, mul_start_d;
    logic [31:0]    mul_a_q, mul_a_d;
    logic [31:0]    mul_b_q, mul_b_d;
    logic           mul_stb_q, mul_stb_d;

    logic [31:0]    a_arr [N_REQ];
    logic [31:0]    b_arr [N_REQ];
    logic           grant_found;
    logic [PW-1:0]  grant_idx;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[32*g +: 32];
        assign b_arr[g] = req_b[32*g +: 32];
    end

    // First valid requester strictly after the last grant, wrapping around.
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_idx   = ptr_q;
        cand        = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!grant_found && req_valid[PW'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        ptr_d        = ptr_q;
        wd_d         = wd_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_z_d     = resp_z_q;
        resp_err_d   = resp_err_q;
        mul_start_d  = 1'b0;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_stb_d    = mul_stb_q;

        unique case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready_d[grant_idx] = 1'b1;
                    mul_a_d     = a_arr[grant_idx];
                    mul_b_d     = b_arr[grant_idx];
                    ptr_d       = grant_idx;
                    mul_start_d = 1'b1;
                    mul_stb_d   = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT_CLR;
            end
            WAIT_CLR, WAIT_DONE: begin
                if (state_q == WAIT_DONE && mul_z_stb) begin
                    resp_z_d              = mul_z;
                    resp_err_d            = 1'b0;
                    mul_stb_d             = 1'b0;
                    resp_valid_d[ptr_q]   = 1'b1;
                    state_d               = RESPOND;
                end else if (wd_q == WW'(TIMEOUT_CYC - 1)) begin
                    resp_z_d   = ABORT_Z;
                    resp_err_d = 1'b1;
                    mul_stb_d  = 1'b0;
                    wd_d       = '0;
                    state_d    = ABORT;
                end else begin
                    wd_d = wd_q + WW'(1);
                    // A still-high level here belongs to the previous op.
                    if (state_q == WAIT_CLR && !mul_z_stb) state_d = WAIT_DONE;
                end
            end
            RESPOND: state_d = IDLE;
            ABORT: begin
                if (wd_q == WW'(1)) begin
                    resp_valid_d[ptr_q] = 1'b1;
                    state_d             = RESPOND;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= PW'(N_REQ - 1);
            wd_q         <= '0;
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_z_q     <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            mul_start_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            mul_stb_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            wd_q         <= wd_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_z_q     <= resp_z_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
            mul_start_q  <= mul_start_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_stb_q    <= mul_stb_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_z     = resp_z_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
    assign mul_rst    = rst | (state_q == ABORT);
    assign mul_start  = mul_start_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_a_stb  = mul_stb_q;
    assign mul_b_stb  = mul_stb_q;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed bench for fpu_mul_arbiter driving a stub multiplier whose completion
// level drops a few cycles after load, so a stale level is visible to the arbiter.
module tb_fpu_mul_arbiter;
    localparam int N        = 4;
    localparam int TO       = 16;
    localparam int CLR_LAT  = 2;
    localparam int DONE_LAT = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [32*N-1:0] req_a, req_b;
    logic [N-1:0]   req_ready, resp_valid;
    logic [31:0]    resp_z;
    logic           resp_err, busy, mul_rst, mul_start;
    logic [31:0]    mul_a, mul_b;
    logic           mul_a_stb, mul_b_stb;
    logic [31:0]    mul_z;
    logic           mul_z_stb;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fpu_mul_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_z(resp_z), .resp_err(resp_err), .busy(busy),
        .mul_rst(mul_rst), .mul_start(mul_start),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_a_stb(mul_a_stb), .mul_b_stb(mul_b_stb),
        .mul_z(mul_z), .mul_z_stb(mul_z_stb)
    );

    // Stub multiplier: products of the operand pairs used below.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return 32'h40C00000;
            {32'h40400000, 32'h40000000}: return 32'h40C00000;
            {32'h3FC00000, 32'h3FC00000}: return 32'h40100000;
            {32'h3F800000, 32'hBF800000}: return 32'hBF800000;
            {32'h7F800000, 32'h00000000}: return 32'hFFC00000;
            {32'h3F800000, 32'h40000000}: return 32'h40000000;
            {32'h40000000, 32'h40000000}: return 32'h40800000;
            {32'h40800000, 32'h40000000}: return 32'h41000000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    logic        hang;
    logic        prev_a_stb, s_busy;
    int          s_cnt;
    logic [31:0] s_a, s_b;

    always @(posedge clk) begin
        if (mul_rst) begin
            mul_z_stb  <= 1'b0;
            mul_z      <= '0;
            s_busy     <= 1'b0;
            s_cnt      <= 0;
            prev_a_stb <= 1'b0;
        end else begin
            prev_a_stb <= mul_a_stb;
            if (mul_a_stb && !prev_a_stb) begin
                s_busy <= 1'b1;
                s_cnt  <= 0;
                s_a    <= mul_a;
                s_b    <= mul_b;
            end else if (s_busy) begin
                s_cnt <= s_cnt + 1;
                if (s_cnt == CLR_LAT) mul_z_stb <= 1'b0;
                if (s_cnt == DONE_LAT && !hang) begin
                    mul_z_stb <= 1'b1;
                    mul_z     <= fmul(s_a, s_b);
                    s_busy    <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"},  32'(req_ready), 32'h0);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'h0);
        check({tag, " resp_z"},     resp_z, 32'h0);
        check({tag, " resp_err"},   32'(resp_err), 32'h0);
        check({tag, " busy"},       32'(busy), 32'h0);
        check({tag, " mul_start"},  32'(mul_start), 32'h0);
        check({tag, " strobes"},    {30'h0, mul_a_stb, mul_b_stb}, 32'h0);
        check({tag, " mul_a"},      mul_a, 32'h0);
        check({tag, " mul_b"},      mul_b, 32'h0);
        check({tag, " mul_rst"},    32'(mul_rst), 32'h1);
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (req_ready == '0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (resp_valid == '0 && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_op(input string tag, input int r, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] z, input logic err);
        int cyc;
        req_valid = N'(1) << r;
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
        @(negedge clk);
        wait_ready(cyc);
        check({tag, " ready"},  32'(req_ready), 32'(1 << r));
        check({tag, " ready latency"}, cyc, 0);
        check({tag, " start"},  32'(mul_start), 32'h1);
        req_valid = '0;
        wait_resp(cyc);
        check({tag, " resp_valid"}, 32'(resp_valid), 32'(1 << r));
        check({tag, " resp_z"},     resp_z, z);
        check({tag, " resp_err"},   32'(resp_err), 32'(err));
        @(negedge clk);
        check({tag, " idle"}, 32'(busy), 32'h0);
    endtask

    typedef struct {
        string       tag;
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic        err;
    } vec_t;

    vec_t vecs[5];
    logic [31:0] rr_exp[N];

    initial begin
        int cyc;
        int k;
        logic seen;

        vecs[0] = '{"mul 2x3",    0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0};
        vecs[1] = '{"b2b 1.5^2",  0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0};
        vecs[2] = '{"b2b 1x-1",   0, 32'h3F800000, 32'hBF800000, 32'hBF800000, 1'b0};
        vecs[3] = '{"inf x 0",    2, 32'h7F800000, 32'h00000000, 32'hFFC00000, 1'b0};
        vecs[4] = '{"req3 4x2",   3, 32'h40800000, 32'h40000000, 32'h41000000, 1'b0};
        rr_exp[0] = 32'h40000000;
        rr_exp[1] = 32'h40800000;
        rr_exp[2] = 32'h40C00000;
        rr_exp[3] = 32'h41000000;

        rst = 1'b1; hang = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("mul_rst released", 32'(mul_rst), 32'h0);

        for (int i = 0; i < 5; i++)
            run_op(vecs[i].tag, vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].z, vecs[i].err);

        // Round robin from a fresh pointer with every requester held valid.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32] = (i == 0) ? 32'h3F800000 : (i == 1) ? 32'h40000000 :
                                (i == 2) ? 32'h40400000 : 32'h40800000;
            req_b[i*32 +: 32] = 32'h40000000;
        end
        req_valid = '1;
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            wait_ready(cyc);
            check($sformatf("rr grant %0d", g), 32'(req_ready), 32'(1 << (g % N)));
            if (g == 4) req_valid = '0;
            wait_resp(cyc);
            check($sformatf("rr resp %0d", g), 32'(resp_valid), 32'(1 << (g % N)));
            check($sformatf("rr z %0d", g), resp_z, rr_exp[g % N]);
            @(negedge clk);
        end

        // Watchdog: the multiplier never completes.
        hang = 1'b1;
        req_valid = 4'b0010;
        req_a[32 +: 32] = 32'h40000000;
        req_b[32 +: 32] = 32'h40400000;
        @(negedge clk);
        wait_ready(cyc);
        check("wd ready", 32'(req_ready), 32'h2);
        req_valid = '0;
        k = 0;
        while (!mul_rst && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("wd abort cycle", k, 17);
        check("wd strobes low", {30'h0, mul_a_stb, mul_b_stb}, 32'h0);
        @(negedge clk);
        check("wd mul_rst 2nd", 32'(mul_rst), 32'h1);
        @(negedge clk);
        check("wd mul_rst end", 32'(mul_rst), 32'h0);
        check("wd resp_valid",  32'(resp_valid), 32'h2);
        check("wd resp_z",      resp_z, 32'h7FC00000);
        check("wd resp_err",    32'(resp_err), 32'h1);
        @(negedge clk);
        hang = 1'b0;
        run_op("post abort", 1, 32'h40400000, 32'h40000000, 32'h40C00000, 1'b0);

        // Reset in the middle of an operation.
        req_valid = 4'b0001;
        req_a[31:0] = 32'h3FC00000;
        req_b[31:0] = 32'h3FC00000;
        @(negedge clk);
        wait_ready(cyc);
        check("midrst ready", 32'(req_ready), 32'h1);
        req_valid = '0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid != '0) seen = 1'b1;
        end
        check("midrst no resp", 32'(seen), 32'h0);
        run_op("after rst", 0, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/fpu_mul_arbiter.md
Name: fpu_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one fpu_multiplier instance among N_REQ processing-element requesters. It accepts an operand pair from one requester, runs the multiplier start/strobe handshake, and waits for a fresh completion. It then returns the product to the owning requester. A watchdog aborts and resets a hung multiplier.

Parameters:
N_REQ, 4, number of requesters (2..16)
TIMEOUT_CYC, 256, max cycles from mul_start to completion before abort (>=16)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  N_REQ  per-requester operand pair valid; held until req_ready
req_a  in  32*N_REQ  operand A, requester i at [32i+31:32i]
req_b  in  32*N_REQ  operand B, same packing
req_ready  out  N_REQ  one-hot 1-cycle pulse: operands of requester i accepted
resp_valid  out  N_REQ  one-hot 1-cycle pulse: result for requester i
resp_z  out  32  result word, valid with resp_valid
resp_err  out  1  result is a watchdog abort, valid with resp_valid
busy  out  1  high whenever state != IDLE
mul_rst  out  1  multiplier reset = rst OR abort pulse
mul_start  out  1  multiplier start
mul_a  out  32  multiplier input_a
mul_b  out  32  multiplier input_b
mul_a_stb  out  1  multiplier input_a_stb
mul_b_stb  out  1  multiplier input_b_stb
mul_z  in  32  multiplier output_z
mul_z_stb  in  1  multiplier output_z_stb (level: rises at completion, falls once next op loads A; undefined after reset until first op)

Behaviour:
- Reset, all outputs registered: req_ready=0, resp_valid=0, resp_z=0, resp_err=0, busy=0, mul_start=0, mul_a_stb=0, mul_b_stb=0, mul_a=0, mul_b=0. RR pointer = N_REQ-1, so requester 0 has first priority. State=IDLE, watchdog=0. mul_rst follows rst combinationally.
- States: IDLE, ISSUE, WAIT_CLR, WAIT_DONE, RESPOND, ABORT.
- IDLE: if any req_valid, grant = first set bit searching from ptr+1 with wrap. Same edge: latch req_a/req_b of grant into mul_a/mul_b, pulse req_ready[grant], ptr<=grant, go to ISSUE. Otherwise stay.
- ISSUE (1 cycle): mul_start=1, mul_a_stb=mul_b_stb=1; go to WAIT_CLR; watchdog cleared.
- mul_a/mul_b, mul_a_stb and mul_b_stb are held stable from ISSUE until leaving WAIT_DONE. mul_start is high only in ISSUE.
- WAIT_CLR: wait for mul_z_stb==0, which discards the stale completion level of the previous op, then go to WAIT_DONE.
- WAIT_DONE: on mul_z_stb==1, capture mul_z into resp_z, resp_err=0, drop strobes, go to RESPOND.
- RESPOND (1 cycle): resp_valid[ptr]=1; go to IDLE. The next grant can occur on the following cycle.
- Watchdog increments each cycle in WAIT_CLR/WAIT_DONE. On reaching TIMEOUT_CYC: go to ABORT, resp_z=32'h7FC00000, resp_err=1.
- ABORT (2 cycles): mul_rst=1 both cycles, strobes 0. Then go to RESPOND, which delivers the error response.
- Requester dropping req_valid before req_ready: no grant, no effect. Requester re-asserting while its op is in flight is queued by RR like any other.
- Only one op is in flight. req_ready is never asserted outside the IDLE->ISSUE edge.
- rst mid-operation: block returns to IDLE next cycle. No resp_valid is issued for the aborted op. The multiplier is reset through mul_rst.
- resp_valid and req_ready are never asserted in the same cycle.

Test Plan:
- Single op: req 0, a=0x40000000 (2.0), b=0x40400000 (3.0) -> req_ready[0] next edge; mul_start 1 cycle; resp_valid[0] with resp_z=0x40C00000, resp_err=0.
- Back-to-back same requester: 0x3FC00000 x 0x3FC00000, then 0x3F800000 x 0xBF800000 -> 0x40100000 then 0xBF800000. Second result is not taken from the stale mul_z_stb level; WAIT_CLR is entered.
- Round robin: req_valid=4'b1111 held, operand per i = (i+1.0) x 2.0 -> grant order 0,1,2,3,0. Each resp_valid[i] carries 2*(i+1), e.g. i=3 gives 0x41000000.
- Special case: 0x7F800000 (inf) x 0x00000000 -> resp_z=0xFFC00000, resp_err=0.
- Watchdog: stub multiplier never raises z_stb, TIMEOUT_CYC=16 -> abort 16 cycles after WAIT_CLR entry. mul_rst high 2 cycles; resp_valid[i] with resp_z=0x7FC00000, resp_err=1; next request then serviced normally.
- Reset mid-op: assert rst during WAIT_DONE -> all outputs at reset values next cycle, no resp_valid. A later request to requester 0 completes correctly.
